// File: rtl/mips_pkg.sv
// Shared hazard/forwarding definitions for the MIPS pipeline.
// Forward-select encodings, stall FSM states and select helper.
package mips_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LDUSE  = 2'd1,
    BRWAIT = 2'd2
  } hfu_state_e;

  // MEM is the younger producer, so it wins over WB.
  function automatic logic [1:0] fwd_pick(
    input logic mem_hit,
    input logic wb_hit
  );
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/stage_rec_reg.sv
// One pipeline-stage record as tracked by the hazard unit.
// Reset loads a bubble: no write, no load, all fields zero.
module stage_rec_reg #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [AW-1:0] d_dest,
  input  logic          d_regwrite,
  input  logic          d_memtoreg,
  output logic [AW-1:0] q_rs,
  output logic [AW-1:0] q_rt,
  output logic [AW-1:0] q_dest,
  output logic          q_regwrite,
  output logic          q_memtoreg
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_rs       <= '0;
      q_rt       <= '0;
      q_dest     <= '0;
      q_regwrite <= 1'b0;
      q_memtoreg <= 1'b0;
    end else begin
      q_rs       <= d_rs;
      q_rt       <= d_rt;
      q_dest     <= d_dest;
      q_regwrite <= d_regwrite;
      q_memtoreg <= d_memtoreg;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and EX operand forwarding for the 5-stage core.
// Selects and stalls are combinational; records, FSM, counter are state.
module hazard_forward_unit
  import mips_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_memtoreg,
  input  logic              id_branch,
  input  logic              id_branch_taken,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              bubble_ex,
  output logic              flush_ifid,
  output logic [CNT_W-1:0]  stall_count
);

  logic [REG_AW-1:0] ex_rs, ex_rt, ex_dest;
  logic [REG_AW-1:0] mem_rs, mem_rt, mem_dest;
  logic [REG_AW-1:0] wb_rs, wb_rt, wb_dest;
  logic              ex_rw, ex_m2r;
  logic              mem_rw, mem_m2r;
  logic              wb_rw, wb_m2r;

  logic [REG_AW-1:0] nx_rs, nx_rt, nx_dest;
  logic              nx_rw, nx_m2r;

  logic       ld_use;
  logic       br_stall;
  logic       stall;
  hfu_state_e state;

  // r0 is hardwired zero, so it never creates a dependency.
  function automatic logic hit(
    input logic [REG_AW-1:0] a,
    input logic [REG_AW-1:0] d,
    input logic              en
  );
    return en && (d != '0) && (a == d);
  endfunction

  always_comb begin
    ld_use = (id_rs_used && hit(id_rs, ex_dest, ex_m2r))
          || (id_rt_used && hit(id_rt, ex_dest, ex_m2r));
    br_stall = id_branch && (
         (id_rs_used && (hit(id_rs, ex_dest, ex_rw)
                      || hit(id_rs, mem_dest, mem_m2r)))
      || (id_rt_used && (hit(id_rt, ex_dest, ex_rw)
                      || hit(id_rt, mem_dest, mem_m2r))));
    stall = !rst && (ld_use || br_stall);
  end

  always_comb begin
    fwd_a_sel  = fwd_pick(hit(ex_rs, mem_dest, mem_rw),
                          hit(ex_rs, wb_dest, wb_rw));
    fwd_b_sel  = fwd_pick(hit(ex_rt, mem_dest, mem_rw),
                          hit(ex_rt, wb_dest, wb_rw));
    stall_pc   = stall;
    stall_ifid = stall;
    bubble_ex  = stall;
    flush_ifid = !rst && id_branch && id_branch_taken && !stall;
  end

  always_comb begin
    nx_rs   = '0;
    nx_rt   = '0;
    nx_dest = '0;
    nx_rw   = 1'b0;
    nx_m2r  = 1'b0;
    if (!stall) begin
      nx_rs   = id_rs;
      nx_rt   = id_rt;
      nx_dest = id_dest;
      nx_rw   = id_regwrite;
      nx_m2r  = id_memtoreg;
    end
  end

  stage_rec_reg #(.AW(REG_AW)) u_ex (
    .clk        (clk),
    .rst        (rst),
    .d_rs       (nx_rs),
    .d_rt       (nx_rt),
    .d_dest     (nx_dest),
    .d_regwrite (nx_rw),
    .d_memtoreg (nx_m2r),
    .q_rs       (ex_rs),
    .q_rt       (ex_rt),
    .q_dest     (ex_dest),
    .q_regwrite (ex_rw),
    .q_memtoreg (ex_m2r)
  );

  stage_rec_reg #(.AW(REG_AW)) u_mem (
    .clk        (clk),
    .rst        (rst),
    .d_rs       (ex_rs),
    .d_rt       (ex_rt),
    .d_dest     (ex_dest),
    .d_regwrite (ex_rw),
    .d_memtoreg (ex_m2r),
    .q_rs       (mem_rs),
    .q_rt       (mem_rt),
    .q_dest     (mem_dest),
    .q_regwrite (mem_rw),
    .q_memtoreg (mem_m2r)
  );

  stage_rec_reg #(.AW(REG_AW)) u_wb (
    .clk        (clk),
    .rst        (rst),
    .d_rs       (mem_rs),
    .d_rt       (mem_rt),
    .d_dest     (mem_dest),
    .d_regwrite (mem_rw),
    .d_memtoreg (mem_m2r),
    .q_rs       (wb_rs),
    .q_rt       (wb_rt),
    .q_dest     (wb_dest),
    .q_regwrite (wb_rw),
    .q_memtoreg (wb_m2r)
  );

  // Late-stage sources are carried for debug visibility only.
  logic rec_unused;
  assign rec_unused = ^{mem_rs, mem_rt, wb_rs, wb_rt, wb_m2r};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else if (ld_use) begin
      state <= LDUSE;
    end else if (br_stall) begin
      state <= BRWAIT;
    end else begin
      state <= RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: directed instruction
// streams push expected outputs, a negedge monitor pops and compares.
module tb_hazard_forward_unit;
  import mips_pkg::*;

  localparam int AW = 5;
  localparam int CW = 8;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic          id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic          id_regwrite = 1'b0, id_memtoreg = 1'b0;
  logic          id_branch = 1'b0, id_branch_taken = 1'b0;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          stall_pc, stall_ifid, bubble_ex, flush_ifid;
  logic [CW-1:0] stall_count;

  hazard_forward_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rs_used      (id_rs_used),
    .id_rt_used      (id_rt_used),
    .id_dest         (id_dest),
    .id_regwrite     (id_regwrite),
    .id_memtoreg     (id_memtoreg),
    .id_branch       (id_branch),
    .id_branch_taken (id_branch_taken),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .stall_pc        (stall_pc),
    .stall_ifid      (stall_ifid),
    .bubble_ex       (bubble_ex),
    .flush_ifid      (flush_ifid),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsu;
    logic       rtu;
    logic [4:0] dest;
    logic       rw;
    logic       m2r;
    logic       br;
    logic       bt;
  } instr_t;

  typedef struct {
    int         id;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       fl;
    logic [CW-1:0] cnt;
    int         stv;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_assert = 0;
  int n_fail = 0;
  int step_no = 0;

  function automatic instr_t nop();
    instr_t i;
    i = '0;
    return i;
  endfunction

  function automatic instr_t alu(input int d, input int s, input int t);
    instr_t i;
    i = '0;
    i.rs = 5'(s); i.rt = 5'(t); i.rsu = 1'b1; i.rtu = 1'b1;
    i.dest = 5'(d); i.rw = 1'b1;
    return i;
  endfunction

  function automatic instr_t lw(input int d, input int s);
    instr_t i;
    i = '0;
    i.rs = 5'(s); i.rsu = 1'b1;
    i.dest = 5'(d); i.rw = 1'b1; i.m2r = 1'b1;
    return i;
  endfunction

  function automatic instr_t beq(input int s, input int t, input logic tk);
    instr_t i;
    i = '0;
    i.rs = 5'(s); i.rt = 5'(t); i.rsu = 1'b1; i.rtu = 1'b1;
    i.br = 1'b1; i.bt = tk;
    return i;
  endfunction

  task automatic chk(input string name, input int id,
                     input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d want %0d", name, id, act, req);
    end
  endtask

  task automatic issue(input logic r, input instr_t i,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic st, input logic fl,
                       input int cnt, input int stv);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r;
    id_rs = i.rs; id_rt = i.rt;
    id_rs_used = i.rsu; id_rt_used = i.rtu;
    id_dest = i.dest; id_regwrite = i.rw; id_memtoreg = i.m2r;
    id_branch = i.br; id_branch_taken = i.bt;
    step_no++;
    x.id = step_no; x.fa = fa; x.fb = fb; x.st = st; x.fl = fl;
    x.cnt = CW'(cnt); x.stv = stv;
    q.push_back(x);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fwd_a_sel", e.id, 32'(fwd_a_sel), 32'(e.fa));
        chk("fwd_b_sel", e.id, 32'(fwd_b_sel), 32'(e.fb));
        chk("stall_pc", e.id, 32'(stall_pc), 32'(e.st));
        chk("stall_ifid", e.id, 32'(stall_ifid), 32'(e.st));
        chk("bubble_ex", e.id, 32'(bubble_ex), 32'(e.st));
        chk("flush_ifid", e.id, 32'(flush_ifid), 32'(e.fl));
        chk("stall_count", e.id, 32'(stall_count), 32'(e.cnt));
        if (e.stv >= 0)
          chk("state", e.id, 32'(dut.state), 32'(e.stv));
      end
    end
  end

  initial begin
    int k;
    int waits;
    // reset: zeroed records and a taken branch must not stall/flush
    issue(1, beq(0, 0, 1), 0, 0, 0, 0, 0, int'(RUN));
    issue(1, beq(0, 0, 1), 0, 0, 0, 0, 0, int'(RUN));
    // back-to-back ALU dependency, then with one NOP between
    issue(0, alu(3, 1, 2), 0, 0, 0, 0, 0, int'(RUN));
    issue(0, alu(4, 3, 1), 0, 0, 0, 0, 0, -1);
    issue(0, nop(),        2, 0, 0, 0, 0, -1);
    issue(0, nop(),        0, 0, 0, 0, 0, -1);
    issue(0, alu(3, 1, 2), 0, 0, 0, 0, 0, -1);
    issue(0, nop(),        0, 0, 0, 0, 0, -1);
    issue(0, alu(4, 3, 1), 0, 0, 0, 0, 0, -1);
    issue(0, nop(),        1, 0, 0, 0, 0, -1);
    issue(0, nop(),        0, 0, 0, 0, 0, -1);
    // load-use
    issue(0, lw(5, 1),     0, 0, 0, 0, 0, -1);
    issue(0, alu(6, 5, 5), 0, 0, 1, 0, 0, int'(RUN));
    issue(0, alu(6, 5, 5), 0, 0, 0, 0, 1, int'(LDUSE));
    issue(0, nop(),        1, 1, 0, 0, 1, int'(RUN));
    issue(0, nop(),        0, 0, 0, 0, 1, -1);
    // branch on a load result: two stalls, then flush
    issue(0, lw(7, 1),       0, 0, 0, 0, 1, -1);
    issue(0, beq(7, 0, 1),   0, 0, 1, 0, 1, int'(RUN));
    issue(0, beq(7, 0, 1),   0, 0, 1, 0, 2, int'(LDUSE));
    issue(0, beq(7, 0, 1),   0, 0, 0, 1, 3, int'(BRWAIT));
    issue(0, nop(),          0, 0, 0, 0, 3, int'(RUN));
    // writes to r0 never forward or stall
    issue(0, alu(0, 1, 2),   0, 0, 0, 0, 3, -1);
    issue(0, lw(0, 1),       0, 0, 0, 0, 3, -1);
    issue(0, alu(8, 0, 0),   0, 0, 0, 0, 3, -1);
    issue(0, beq(0, 0, 1),   0, 0, 0, 1, 3, -1);
    issue(0, nop(),          0, 0, 0, 0, 3, -1);
    // MEM and WB both write r2: MEM wins
    issue(0, alu(2, 1, 1),   0, 0, 0, 0, 3, -1);
    issue(0, alu(2, 3, 3),   0, 0, 0, 0, 3, -1);
    issue(0, alu(9, 2, 2),   0, 0, 0, 0, 3, -1);
    issue(0, nop(),          2, 2, 0, 0, 3, -1);
    issue(0, nop(),          0, 0, 0, 0, 3, -1);
    // reset during LDUSE
    issue(0, lw(5, 1),       0, 0, 0, 0, 3, -1);
    issue(0, alu(6, 5, 5),   0, 0, 1, 0, 3, -1);
    issue(1, beq(5, 0, 1),   0, 0, 0, 0, 0, int'(RUN));
    issue(1, beq(5, 0, 1),   0, 0, 0, 0, 0, int'(RUN));
    issue(0, beq(5, 0, 0),   0, 0, 0, 0, 0, int'(RUN));
    // counter saturation: 2^CW+3 forced load-use stalls
    k = 0;
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      issue(0, lw(5, 1),     0, 0, 0, 0, (k > SAT) ? SAT : k, -1);
      issue(0, alu(6, 5, 5), 0, 0, 1, 0, (k > SAT) ? SAT : k, -1);
      k++;
    end
    issue(0, nop(), 0, 0, 0, 0, SAT, -1);
    issue(0, nop(), 0, 0, 0, 0, SAT, int'(RUN));

    waits = 0;
    while (q.size() > 0 && waits < 10) begin
      @(posedge clk);
      waits++;
    end
    if (q.size() > 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
